// File: rtl/rom_arb_pkg.sv
// Shared types and default sizes for the program-ROM port arbiter.
package rom_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_WAIT   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DL   = 2'b10
    } owner_e;

endpackage

// File: rtl/rom_arb_select.sv
// Combinational grant selection between instruction fetch (IF) and data load (DL).
// ROM_ARB_RR_EN selects round-robin on contention instead of DL priority with IF starvation override.
module rom_arb_select #(
    parameter int MAX_WAIT = 4
) (
    input  logic       if_req,
    input  logic       dl_req,
`ifdef ROM_ARB_RR_EN
    input  logic       last_if,
`else
    input  logic [3:0] wait_cnt,
`endif
    output logic       if_win,
    output logic       dl_win
);

    // Pick at most one winner per cycle
    always_comb begin
        if_win = 1'b0;
        dl_win = 1'b0;
        if (if_req && dl_req) begin
`ifdef ROM_ARB_RR_EN
            // The port that did not win last time goes first
            if (last_if) begin
                dl_win = 1'b1;
            end else begin
                if_win = 1'b1;
            end
`else
            if (wait_cnt == 4'(MAX_WAIT)) begin
                if_win = 1'b1;
            end else begin
                dl_win = 1'b1;
            end
`endif
        end else if (if_req) begin
            if_win = 1'b1;
        end else if (dl_req) begin
            dl_win = 1'b1;
        end else begin
            if_win = 1'b0;
            dl_win = 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous-read program ROM between the IF and DL ports, tagging each access
// so the word returned a cycle later is steered to its owner. Optional macro: ROM_ARB_RR_EN.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dl_req,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    output logic                  dl_gnt,
    output logic                  dl_rvalid,
    output logic [DATA_WIDTH-1:0] dl_rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    logic   if_win_s;
    logic   dl_win_s;
    owner_e owner_r;
    owner_e owner_nxt_s;

`ifdef ROM_ARB_RR_EN
    logic last_if_r;

    rom_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
        .if_req  (if_req),
        .dl_req  (dl_req),
        .last_if (last_if_r),
        .if_win  (if_win_s),
        .dl_win  (dl_win_s)
    );

    // Remember which port was granted most recently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_if_r <= 1'b1;
        end else if (if_gnt) begin
            last_if_r <= 1'b1;
        end else if (dl_gnt) begin
            last_if_r <= 1'b0;
        end
    end
`else
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_nxt_s;

    rom_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
        .if_req   (if_req),
        .dl_req   (dl_req),
        .wait_cnt (wait_cnt_r),
        .if_win   (if_win_s),
        .dl_win   (dl_win_s)
    );

    // Count consecutive cycles IF is denied, saturating at MAX_WAIT
    always_comb begin
        wait_cnt_nxt_s = 4'd0;
        if (if_req && !if_gnt) begin
            if (wait_cnt_r == 4'(MAX_WAIT)) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + 4'd1;
            end
        end else begin
            wait_cnt_nxt_s = 4'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end
`endif

    // Grants are suppressed while reset is held so nothing is issued to the ROM
    assign if_gnt   = if_win_s & reset;
    assign dl_gnt   = dl_win_s & reset;
    assign rom_addr = dl_gnt ? dl_addr : if_addr;

    // Tag for the access the ROM is serving next cycle
    always_comb begin
        owner_nxt_s = OWN_NONE;
        if (if_gnt) begin
            owner_nxt_s = OWN_IF;
        end else if (dl_gnt) begin
            owner_nxt_s = OWN_DL;
        end else begin
            owner_nxt_s = OWN_NONE;
        end
    end

    // Owner tag register; reset drops any response in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_nxt_s;
        end
    end

    assign if_rvalid = (owner_r == OWN_IF);
    assign dl_rvalid = (owner_r == OWN_DL);
    assign if_rdata  = rom_q;
    assign dl_rdata  = rom_q;

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single synchronous-read program ROM (4096x32, 1-cycle registered output, async active-low reset) between two requesters: the CPU instruction-fetch port (IF) and the data/constant-table load port (DL).
- Arbitrates one access per cycle, drives the ROM address, and tags each access so the returned word is steered back to its owner one cycle later.
- Sits between the TRISC3A core's fetch and load units and the ROM instance.

Parameters:
- DATA_WIDTH, 32, ROM word width.
- ADDR_WIDTH, 12, ROM address width (2**ADDR_WIDTH words).
- MAX_WAIT, 4, consecutive cycles IF may be denied before it is forced to win; range 1..15.

Ports:
- clk  input  1  system clock, all registers rising-edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  IF request; level, held until granted.
- if_addr  input  ADDR_WIDTH  IF word address.
- if_gnt  output  1  IF request accepted this cycle.
- if_rvalid  output  1  if_rdata valid this cycle.
- if_rdata  output  DATA_WIDTH  IF read data.
- dl_req  input  1  DL request; level, held until granted.
- dl_addr  input  ADDR_WIDTH  DL word address.
- dl_gnt  output  1  DL request accepted this cycle.
- dl_rvalid  output  1  dl_rdata valid this cycle.
- dl_rdata  output  DATA_WIDTH  DL read data.
- rom_addr  output  ADDR_WIDTH  to ROM address input.
- rom_q  input  DATA_WIDTH  from ROM data output.

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-low.
- Reset values: if_rvalid=0, dl_rvalid=0, wait counter=0, owner tag=NONE, last-winner=IF. if_gnt/dl_gnt are combinational and forced 0 while reset is low.
- Grant (combinational, cycle N):
  - Only one requester: it is granted.
  - Both requesting: DL wins by default, unless wait_cnt==MAX_WAIT, in which case IF wins.
  - Exactly one of if_gnt/dl_gnt is 1 at most.
- rom_addr = granted requester's address. With no grant, rom_addr = if_addr (deterministic idle value).
- The ROM samples rom_addr at the end of cycle N. rom_q is valid in cycle N+1.
- Response (cycle N+1): the registered owner tag selects the port.
  - xx_rvalid=1 for exactly one cycle.
  - if_rdata and dl_rdata both wire to rom_q; only the owning port's rvalid qualifies it.
- Latency: grant to rvalid = 1 cycle. Back-to-back grants are allowed every cycle (full throughput).
- Starvation counter wait_cnt (4 bits, saturating at MAX_WAIT):
  - Increments when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Owner tag states: NONE, IF, DL. Next tag = granted port, or NONE if no grant.
- Boundary conditions:
  - Address wrap: none; addresses are used as-is.
  - Request dropped before grant: legal, no response.
  - Reset asserted mid-access: pending response discarded, rvalid=0 immediately. Requesters must re-request after reset release.
  - Both requests in the first cycle after reset: DL granted.

Optional Feature:
- Macro ROM_ARB_RR_EN.
- Defined: on simultaneous requests, round-robin using the last-winner register (the port that did not win last time wins). The wait counter and MAX_WAIT are not instantiated.
- Undefined: fixed DL priority with the MAX_WAIT anti-starvation override, as above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package rom_arb_pkg:
  - owner tag enum (OWN_NONE=2'b00, OWN_IF=2'b01, OWN_DL=2'b10).
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, rom_arb_select: combinational grant logic (priority / round-robin / starvation override). The top holds the registers and the response steering.

Test Plan:
- IF only, if_addr=0x010 for 3 cycles -> if_gnt=1 each cycle; if_rvalid=1 from the next cycle with rom[0x010]; dl_rvalid stays 0.
- Both requesting, if_addr=0x020, dl_addr=0x800, MAX_WAIT=4 -> DL granted cycles 0-3, IF granted cycle 4; if_rvalid in cycle 5 with rom[0x020].
- Single DL request at 0xFFF -> dl_gnt=1 one cycle; dl_rvalid=1 next cycle with rom[0xFFF]; no wrap or aliasing.
- Reset pulled low in the cycle after dl_gnt for dl_addr=0x100 -> dl_rvalid=0 immediately; after release, no stale response; gnt outputs 0 during reset.
- ROM_ARB_RR_EN defined, both requesting continuously -> grants alternate DL, IF, DL, IF starting with DL; rvalids alternate one cycle later.
- No requests for 5 cycles -> no gnt, no rvalid; rom_addr follows if_addr.
